// File: rtl/ca_row_engine_if.sv
// Bus between the CA row engine and its environment: control handshake plus the byte-wide RAM port.
interface ca_row_engine_if #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned ROW_IDX_W = 6
);
    logic                 start;
    logic [7:0]           rule;
    logic [ADDR_W-1:0]    ram_addr;
    logic [7:0]           ram_rd_data;
    logic [7:0]           ram_wr_data;
    logic                 ram_we;
    logic                 busy;
    logic                 done;
    logic [ROW_IDX_W-1:0] cur_row;

    // Engine side
    modport master (
        input  start, rule, ram_rd_data,
        output ram_addr, ram_wr_data, ram_we, busy, done, cur_row
    );

    // Environment side (sequencer / RAM)
    modport slave (
        output start, rule, ram_rd_data,
        input  ram_addr, ram_wr_data, ram_we, busy, done, cur_row
    );
endinterface

// File: rtl/ca_row_engine.sv
// Elementary cellular-automaton engine: reads one row from RAM, applies a Wolfram rule
// with toroidal wrap, and writes the next generation into the following ring-buffer slot.
module ca_row_engine #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned ROW_BYTES = 16,
    parameter int unsigned NUM_ROWS  = 64
) (
    input  logic            clk,
    input  logic            reset,
    ca_row_engine_if.master bus
);
    localparam int unsigned W          = 8 * ROW_BYTES;
    localparam int unsigned ROW_IDX_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned BYTE_IDX_W = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
    localparam int unsigned CNT_W      = $clog2(ROW_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [7:0]                     rule_q, rule_d;
    logic [ROW_BYTES-1:0][7:0]      row_q, row_d;
    logic [ROW_BYTES-1:0][7:0]      nrow_q, nrow_d;
    logic [ADDR_W-1:0]              ram_addr_q, ram_addr_d;
    logic [7:0]                     ram_wr_data_q, ram_wr_data_d;
    logic                           ram_we_q, ram_we_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [ROW_IDX_W-1:0]           cur_row_q, cur_row_d;

    logic [ROW_IDX_W-1:0]           dst_row_c;
    logic [ADDR_W-1:0]              src_base_c;
    logic [ADDR_W-1:0]              dst_base_c;
    logic [W-1:0]                   old_cells_c;
    logic [ROW_BYTES-1:0][7:0]      next_row_c;

    // Source/destination row selection; the last ring slot wraps to row 0
    always_comb begin
        dst_row_c  = (cur_row_q == ROW_IDX_W'(NUM_ROWS - 1)) ? '0 : cur_row_q + ROW_IDX_W'(1);
        src_base_c = ADDR_W'(cur_row_q) * ADDR_W'(ROW_BYTES);
        dst_base_c = ADDR_W'(dst_row_c) * ADDR_W'(ROW_BYTES);
    end

    // Next generation of every cell; bit 7 of each byte is the leftmost cell
    always_comb begin
        old_cells_c = '0;
        next_row_c  = '0;
        for (int unsigned i = 0; i < W; i++) begin
            old_cells_c[i] = row_q[i / 8][7 - (i % 8)];
        end
        for (int unsigned i = 0; i < W; i++) begin
            next_row_c[i / 8][7 - (i % 8)] = rule_q[{old_cells_c[(i + W - 1) % W],
                                                      old_cells_c[i],
                                                      old_cells_c[(i + 1) % W]}];
        end
    end

    // Sequencer next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rule_d        = rule_q;
        row_d         = row_q;
        nrow_d        = nrow_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        ram_we_d      = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        cur_row_d     = cur_row_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    rule_d     = bus.rule;
                    state_d    = S_READ;
                    cnt_d      = '0;
                    ram_addr_d = src_base_c;
                    busy_d     = 1'b1;
                end
            end

            // Address byte k goes out in read cycle k; its data lands in cycle k+1
            S_READ: begin
                for (int unsigned j = 0; j < ROW_BYTES; j++) begin
                    if (cnt_q == CNT_W'(j + 1)) begin
                        row_d[j] = bus.ram_rd_data;
                    end
                end
                if (cnt_q < CNT_W'(ROW_BYTES - 1)) begin
                    ram_addr_d = src_base_c + ADDR_W'(cnt_q) + ADDR_W'(1);
                end
                if (cnt_q == CNT_W'(ROW_BYTES)) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CALC: begin
                nrow_d  = next_row_c;
                state_d = S_WRITE;
                cnt_d   = '0;
            end

            // Each count loads one write beat into the output registers
            S_WRITE: begin
                if (cnt_q < CNT_W'(ROW_BYTES)) begin
                    ram_addr_d    = dst_base_c + ADDR_W'(cnt_q);
                    ram_wr_data_d = nrow_q[cnt_q[BYTE_IDX_W-1:0]];
                    ram_we_d      = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                end else begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    cur_row_d = dst_row_c;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any run immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rule_q        <= '0;
            row_q         <= '0;
            nrow_q        <= '0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cur_row_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rule_q        <= rule_d;
            row_q         <= row_d;
            nrow_q        <= nrow_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_we_q      <= ram_we_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cur_row_q     <= cur_row_d;
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wr_data = ram_wr_data_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cur_row     = cur_row_q;

endmodule

// File: tb/tb_ca_row_engine.sv
// Directed bench for ca_row_engine with a behavioural 1-cycle-latency byte RAM.
module tb_ca_row_engine;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned ROW_BYTES = 16;
    localparam int unsigned NUM_ROWS  = 64;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ca_row_engine_if #(.ADDR_W(ADDR_W), .ROW_IDX_W(6)) bus ();

    ca_row_engine #(
        .ADDR_W   (ADDR_W),
        .ROW_BYTES(ROW_BYTES),
        .NUM_ROWS (NUM_ROWS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] mem [1024] = '{default: 8'h00};
    logic [9:0] wlog [4096];
    int         wr_total   = 0;
    int         done_total = 0;
    logic       tb_we;
    logic [9:0] tb_addr;
    logic [7:0] tb_data;

    // RAM model, write log and done counter
    always @(posedge clk) begin
        bus.ram_rd_data <= mem[bus.ram_addr];
        if (bus.ram_we) begin
            mem[bus.ram_addr]   <= bus.ram_wr_data;
            wlog[wr_total % 4096] <= bus.ram_addr;
            wr_total            <= wr_total + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
        if (bus.done) done_total <= done_total + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One start pulse; lat = edges from acceptance to the first cycle with done high
    task automatic do_run(input logic [7:0] r, output int lat, output logic [9:0] first_rd);
        @(negedge clk);
        bus.start = 1'b1; bus.rule = r;
        @(negedge clk);
        bus.start = 1'b0; bus.rule = ~r;
        first_rd = bus.ram_addr;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    logic [7:0] r0   [16];
    logic [7:0] expv [16];
    int         lat;
    logic [9:0] frd;
    int         wbase;
    int         dbase;
    int         guard;

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.rule = 8'h00;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_addr", 32'(bus.ram_addr), 0);
        check("rst_wdata", 32'(bus.ram_wr_data), 0);
        check("rst_we", 32'(bus.ram_we), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_cur_row", 32'(bus.cur_row), 0);

        // Single seed, rule 90: cell 64 -> cells 63 and 65
        poke(10'd8, 8'h80);
        wbase = wr_total; dbase = done_total;
        do_run(8'h5A, lat, frd);
        check("r90_latency", 32'(lat), 35);
        check("r90_first_rd", 32'(frd), 0);
        check("r90_busy_after", 32'(bus.busy), 0);
        check("r90_cur_row", 32'(bus.cur_row), 1);
        check("r90_wr_count", 32'(wr_total - wbase), 16);
        check("r90_done_count", 32'(done_total - dbase), 1);
        for (int j = 0; j < 16; j++) begin
            expv[j] = (j == 7) ? 8'h01 : (j == 8) ? 8'h40 : 8'h00;
            check("r90_wr_addr", 32'(wlog[(wbase + j) % 4096]), 32'(16 + j));
            check("r90_byte", 32'(mem[16 + j]), 32'(expv[j]));
        end

        // Wrap-around, rule 90: cell 0 -> cells 127 and 1
        do_reset();
        poke(10'd8, 8'h00);
        poke(10'd0, 8'h80);
        do_run(8'h5A, lat, frd);
        for (int j = 0; j < 16; j++) begin
            expv[j] = (j == 0) ? 8'h40 : (j == 15) ? 8'h01 : 8'h00;
            check("wrap_byte", 32'(mem[16 + j]), 32'(expv[j]));
        end

        // Rule 0xFF then rule 0x00 on a random row
        do_reset();
        do_run(8'hFF, lat, frd);
        for (int j = 0; j < 16; j++) check("rule_ff_byte", 32'(mem[16 + j]), 32'hFF);
        do_reset();
        for (int j = 0; j < 16; j++) begin
            r0[j] = 8'($urandom_range(1, 255));
            poke(10'(j), r0[j]);
        end
        do_run(8'h00, lat, frd);
        for (int j = 0; j < 16; j++) check("rule_00_byte", 32'(mem[16 + j]), 32'h00);

        // Identity rule twice: row 2 equals row 0
        do_reset();
        do_run(8'hCC, lat, frd);
        do_run(8'hCC, lat, frd);
        check("ident_cur_row", 32'(bus.cur_row), 2);
        for (int j = 0; j < 16; j++) check("ident_row2", 32'(mem[32 + j]), 32'(r0[j]));

        // Ring wrap: 63 runs, then the 64th reads row 63 and writes row 0
        do_reset();
        for (int n = 0; n < 63; n++) do_run(8'hCC, lat, frd);
        check("ring_cur_row_63", 32'(bus.cur_row), 63);
        wbase = wr_total;
        do_run(8'hCC, lat, frd);
        check("ring_first_rd", 32'(frd), 1008);
        check("ring_latency", 32'(lat), 35);
        check("ring_cur_row_0", 32'(bus.cur_row), 0);
        check("ring_wr_count", 32'(wr_total - wbase), 16);
        for (int j = 0; j < 16; j++) begin
            check("ring_wr_addr", 32'(wlog[(wbase + j) % 4096]), 32'(j));
            check("ring_row0", 32'(mem[j]), 32'(r0[j]));
        end

        // Start and rule change while busy are ignored
        do_reset();
        for (int j = 0; j < 16; j++) poke(10'(j), (j == 8) ? 8'h80 : 8'h00);
        wbase = wr_total; dbase = done_total;
        @(negedge clk);
        bus.start = 1'b1; bus.rule = 8'h5A;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (guard < 60) begin
            @(negedge clk);
            guard++;
            if (guard == 10) begin bus.start = 1'b1; bus.rule = 8'hFF; end
            else begin bus.start = 1'b0; end
        end
        repeat (40) @(negedge clk);
        check("busy_done_count", 32'(done_total - dbase), 1);
        check("busy_wr_count", 32'(wr_total - wbase), 16);
        check("busy_cur_row", 32'(bus.cur_row), 1);
        check("busy_idle", 32'(bus.busy), 0);
        for (int j = 0; j < 16; j++) begin
            expv[j] = (j == 7) ? 8'h01 : (j == 8) ? 8'h40 : 8'h00;
            check("busy_byte", 32'(mem[16 + j]), 32'(expv[j]));
        end

        // Start together with reset: reset wins
        @(negedge clk);
        reset = 1'b1; bus.start = 1'b1; bus.rule = 8'hCC;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start_busy", 32'(bus.busy), 0);
        check("rst_start_cur_row", 32'(bus.cur_row), 0);

        // Reset during write byte 5 aborts; partial row stays
        for (int j = 0; j < 16; j++) poke(10'(j), r0[j]);
        for (int j = 0; j < 16; j++) poke(10'(16 + j), 8'h33);
        @(negedge clk);
        bus.start = 1'b1; bus.rule = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!(bus.ram_we === 1'b1 && bus.ram_addr === 10'd21) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("midwr_reached", 32'(guard < 100), 1);
        reset = 1'b1;
        #1;
        check("midwr_we", 32'(bus.ram_we), 0);
        check("midwr_busy", 32'(bus.busy), 0);
        check("midwr_cur_row", 32'(bus.cur_row), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            check("midwr_partial", 32'(mem[16 + j]), (j < 5) ? 32'hFF : 32'h33);
        end
        do_run(8'hCC, lat, frd);
        check("post_rst_first_rd", 32'(frd), 0);
        check("post_rst_latency", 32'(lat), 35);
        check("post_rst_cur_row", 32'(bus.cur_row), 1);
        for (int j = 0; j < 16; j++) check("post_rst_row1", 32'(mem[16 + j]), 32'(r0[j]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ca_row_engine.md
Name: ca_row_engine

Overview:
- Elementary (1-D, 3-neighbour) cellular-automaton generation engine; the upstream producer for the display RAM that binary_display scans out.
- Reads generation row r from a byte-wide synchronous RAM port, applies an 8-bit Wolfram rule with toroidal wrap, and writes generation r+1 into the next row slot.
- Runs one row per start pulse. A sequencer or the UART bus triggers it; the bus also seeds and sets the rule.

Parameters:
- ADDR_W, 10, RAM byte-address width.
- ROW_BYTES, 16, bytes per row (W = 8*ROW_BYTES = 128 cells).
- NUM_ROWS, 64, rows in the ring buffer. ROW_BYTES*NUM_ROWS must be <= 2^ADDR_W.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to compute next row; sampled only in IDLE.
- rule  in  8  Wolfram rule number; latched on accepted start.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_rd_data  in  8  RAM read data, valid the cycle after ram_addr is presented (1-cycle latency).
- ram_wr_data  out  8  RAM write data.
- ram_we  out  1  RAM write enable for the current ram_addr/ram_wr_data.
- busy  out  1  high from the cycle after an accepted start through the DONE state.
- done  out  1  one-cycle pulse when the destination row is fully written.
- cur_row  out  log2(NUM_ROWS)  index of the most recently completed generation row (source row of the next run).

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; ram_addr=0, ram_wr_data=0, ram_we=0, busy=0, done=0, cur_row=0; row buffer cleared.
- Cell mapping: cell i lives in byte i/8 at bit 7-(i mod 8), so bit 7 is the leftmost cell. Row base address = row*ROW_BYTES.
- Next state: new[i] = rule_q[{old[(i-1) mod W], old[i], old[(i+1) mod W]}].
  - Cell 0's left neighbour is cell W-1; cell W-1's right neighbour is cell 0.
- src = cur_row; dst = (cur_row+1) mod NUM_ROWS. The row NUM_ROWS-1 wraps to destination row 0.
- FSM:
  - IDLE: if start=1, latch rule_q and go to READ.
  - READ, ROW_BYTES+1 cycles:
    - Cycle k (0..ROW_BYTES-1): ram_addr = src*ROW_BYTES+k, ram_we=0.
    - Cycle k+1: capture ram_rd_data into row-buffer byte k.
    - Go to CALC after the last byte is captured.
  - CALC, 1 cycle: compute all W new cells combinationally from the buffer and register them.
  - WRITE, ROW_BYTES cycles: cycle k drives ram_addr = dst*ROW_BYTES+k, ram_wr_data = new byte k, ram_we=1.
  - DONE, 1 cycle: ram_we=0, done=1, cur_row <= dst. Return to IDLE.
- Latency: start accepted at edge E → done high in the cycle beginning 2*ROW_BYTES+3 edges later (35 with defaults). busy falls with the return to IDLE.
- While busy:
  - start is ignored, not queued.
  - rule changes have no effect.
- ram_we is never high outside WRITE.
- The source row is never written. Only destination-row addresses are written.
- start and reset asserted together: reset wins.
- Reset mid-run aborts immediately.
  - ram_we drops asynchronously. A partially written row is left as is.
  - cur_row returns to 0.

Test Plan:
- Single seed, rule 90 (0x5A):
  - Stimulus: row 0 all zero except addr 8 = 0x80 (cell 64); start.
  - Required: writes to addr 16..31 with addr 23 = 0x01, addr 24 = 0x40, all others 0x00; done exactly 35 cycles after start; cur_row = 1.
- Wrap-around, rule 90:
  - Stimulus: row 0 = addr 0 = 0x80, rest 0; start.
  - Required: addr 16 = 0x40, addr 31 = 0x01, others 0.
- Constant rules:
  - Rule 0x00 on a random row: all 16 written bytes = 0x00.
  - Rule 0xFF: all 16 written bytes = 0xFF.
  - Rule 0xCC (identity), run twice: row 2 equals row 0 byte-for-byte.
- Ring wrap:
  - Stimulus: run 63 starts, then a 64th.
  - Required: 64th run reads addr 1008..1023 and writes addr 0..15; cur_row goes 63 → 0.
- Start while busy / rule change:
  - Stimulus: pulse start and a new rule value at cycle 10 of a run.
  - Required: no second run; written data reflects the original rule; exactly one done pulse.
- Reset mid-WRITE:
  - Stimulus: assert reset during write byte 5.
  - Required: ram_we=0 within the same cycle (asynchronous); busy=0; cur_row=0; next start reads addr 0..15.
